// File: rtl/pixel_write_buffer.sv
// ---------------------------------------------------------------------------
// pixel_write_buffer
//
// Sits downstream of the animation stage's pixel stream. Each incoming pixel
// (x, y, color) is range-checked against the visible area. Its position is
// turned into a linear framebuffer address y*H_RES + x. The pixel is then
// queued in a small FIFO, so the drawing logic never has to stall. The FIFO
// drains one write per pixel into the 1-bit framebuffer port through a
// valid/ready handshake.
//
// Pipeline: stage 1 (range check) -> stage 2 (address multiply) -> FIFO ->
// output register (wr_en / wr_addr / wr_data).
//
// Optional build macro: PIXEL_DEDUP_EN
//   When defined, stage 1 drops a pixel that exactly repeats the previous
//   pixel stage 1 accepted. This removes the duplicates the drawing stage
//   emits while idle.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-high reset, clears all state
//   pixel_valid  x/y/color carry a pixel this cycle
//   x, y         pixel column / row (11 bits each)
//   color        1 = white, 0 = black
//   wr_en        framebuffer write request (valid)
//   wr_addr      framebuffer address, y*H_RES + x
//   wr_data      pixel color to write
//   mem_ready    memory takes the write when wr_en & mem_ready at a clock edge
//   fifo_full    FIFO holds FIFO_DEPTH entries (registered)
//   drop_count   count of pixels lost to overflow; saturates at 16'hFFFF
//   overflow     sticky flag, set on the first drop, cleared only by reset
// ---------------------------------------------------------------------------
module pixel_write_buffer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_valid,
    input  logic [10:0]       x,
    input  logic [10:0]       y,
    input  logic              color,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    input  logic              mem_ready,
    output logic              fifo_full,
    output logic [15:0]       drop_count,
    output logic              overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 1;

    localparam logic [10:0]       LP_H_LIM = 11'(H_RES);
    localparam logic [10:0]       LP_V_LIM = 11'(V_RES);
    localparam logic [ADDR_W-1:0] LP_H_MUL = ADDR_W'(H_RES);
    localparam logic [CNT_W-1:0]  LP_DEPTH = CNT_W'(FIFO_DEPTH);

    // ---------------- stage 1: range check (and optional dedup) ------------
    logic        w_in_range;
    logic        w_dup;
    logic        w_s1_accept;
    logic        r_s1_valid;
    logic [10:0] r_s1_x;
    logic [10:0] r_s1_y;
    logic        r_s1_color;

    assign w_in_range  = pixel_valid && (x < LP_H_LIM) && (y < LP_V_LIM);
    assign w_s1_accept = w_in_range && !w_dup;

`ifdef PIXEL_DEDUP_EN
    // Last pixel that passed the range check. r_last_valid marks the
    // register empty after reset, so the first pixel after reset always passes.
    logic        r_last_valid;
    logic [10:0] r_last_x;
    logic [10:0] r_last_y;
    logic        r_last_color;

    assign w_dup = r_last_valid && (x == r_last_x) && (y == r_last_y)
                   && (color == r_last_color);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_valid <= 1'b0;
            r_last_x     <= '0;
            r_last_y     <= '0;
            r_last_color <= 1'b0;
        end else if (w_in_range) begin
            // A duplicate rewrites identical values, so updating on every
            // in-range pixel is the same as updating on every accepted one.
            r_last_valid <= 1'b1;
            r_last_x     <= x;
            r_last_y     <= y;
            r_last_color <= color;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_color <= 1'b0;
        end else begin
            r_s1_valid <= w_s1_accept;
            r_s1_x     <= x;
            r_s1_y     <= y;
            r_s1_color <= color;
        end
    end

    // ---------------- stage 2: linear address ------------------------------
    // Doing the multiply modulo 2^ADDR_W gives the same result as truncating
    // the full-precision product.
    logic [ADDR_W-1:0] w_s2_addr;
    logic              r_s2_valid;
    logic [ADDR_W-1:0] r_s2_addr;
    logic              r_s2_color;

    assign w_s2_addr = ADDR_W'(r_s1_y) * LP_H_MUL + ADDR_W'(r_s1_x);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_color <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_addr  <= w_s2_addr;
            r_s2_color <= r_s1_color;
        end
    end

    // ---------------- FIFO -------------------------------------------------
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [CNT_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   w_wr_ptr_next;
    logic [CNT_W-1:0]   w_rd_ptr_next;
    logic               r_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_full_next;
    logic [ENTRY_W-1:0] w_head;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_data;
    logic [15:0]       r_drop_count;
    logic              r_overflow;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    // Pop whenever the output register is free or is being emptied this edge.
    assign w_pop        = !w_fifo_empty && (!r_wr_en || mem_ready);
    // A full FIFO still takes a push when a pop frees a slot at the same edge.
    assign w_push       = r_s2_valid && (!r_fifo_full || w_pop);
    assign w_drop       = r_s2_valid && r_fifo_full && !w_pop;

    assign w_wr_ptr_next = r_wr_ptr + {{PTR_W{1'b0}}, w_push};
    assign w_rd_ptr_next = r_rd_ptr + {{PTR_W{1'b0}}, w_pop};
    assign w_full_next   = ((w_wr_ptr_next - w_rd_ptr_next) == LP_DEPTH);
    assign w_head        = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= {r_s2_addr, r_s2_color};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_full <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_fifo_full <= w_full_next;
        end
    end

    // ---------------- output register and overflow accounting --------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 1'b0;
        end else if (w_pop) begin
            r_wr_en                <= 1'b1;
            {r_wr_addr, r_wr_data} <= w_head;
        end else if (mem_ready) begin
            // The write was accepted and nothing is waiting behind it.
            // Address and data keep their last value.
            r_wr_en <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign fifo_full  = r_fifo_full;
    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_pixel_write_buffer
//
// Scoreboard bench. Stimulus pushes the {addr, data} it expects to see
// written. A monitor pops and compares on every accepted write
// (wr_en & mem_ready). Directed checks cover reset values, latency,
// fifo_full, drop_count and overflow.
// ---------------------------------------------------------------------------
module tb_pixel_write_buffer;

    localparam int ADDR_W = 19;

    logic              clk = 1'b0;
    logic              reset;
    logic              pixel_valid;
    logic [10:0]       x;
    logic [10:0]       y;
    logic              color;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              mem_ready;
    logic              fifo_full;
    logic [15:0]       drop_count;
    logic              overflow;

    pixel_write_buffer #(
        .H_RES(640), .V_RES(480), .ADDR_W(ADDR_W), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .reset(reset), .pixel_valid(pixel_valid),
        .x(x), .y(y), .color(color),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_ready(mem_ready), .fifo_full(fifo_full),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [ADDR_W:0] exp_q [$];
    logic [ADDR_W:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("check %s: got %0d ok", name, act);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write the memory accepts must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && wr_en === 1'b1 && mem_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                         wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({wr_addr, wr_data} === mon_e) begin
                    n_pass++;
                    $display("write addr %0d data %0d ok", wr_addr, wr_data);
                end else begin
                    $display("FAIL write_order: got addr %0d data %0d, expected addr %0d data %0d",
                             wr_addr, wr_data, mon_e[ADDR_W:1], mon_e[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] xx, input logic [10:0] yy, input logic c);
        pixel_valid = 1'b1;
        x = xx;
        y = yy;
        color = c;
        tick();
    endtask

    task automatic idle(input int n);
        pixel_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_px(input int a, input logic c);
        logic [ADDR_W-1:0] av;
        av = ADDR_W'(a);
        exp_q.push_back({av, c});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick();
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        pixel_valid = 1'b0;
        x = '0;
        y = '0;
        color = 1'b0;
        mem_ready = 1'b1;
        tick(); tick(); tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;
        idle(2);

        // Single pixel: latency and address 2*640+5.
        expect_px(1285, 1'b1);
        drive(5, 2, 1'b1);          // edge k
        pixel_valid = 1'b0;
        chk("lat_k0_wr_en", wr_en, 0);
        tick();                      // k+1
        chk("lat_k1_wr_en", wr_en, 0);
        tick();                      // k+2
        chk("lat_k2_wr_en", wr_en, 0);
        tick();                      // k+3
        chk("lat_k3_wr_en", wr_en, 1);
        chk("lat_k3_wr_addr", wr_addr, 1285);
        chk("lat_k3_wr_data", wr_data, 1);
        tick();                      // k+4, accepted
        chk("lat_k4_wr_en", wr_en, 0);
        chk("single_drained", exp_q.size(), 0);

        // Out-of-range pixels never produce a write and are not counted.
        drive(640, 0, 1'b1);
        drive(0, 480, 1'b1);
        drive(2047, 2047, 1'b0);
        idle(8);
        chk("oor_wr_en", wr_en, 0);
        chk("oor_drop_count", drop_count, 0);
        chk("oor_overflow", overflow, 0);

        // Repeated pixel (3,3,1) x5, then (3,3,0). Address = 3*640+3.
`ifdef PIXEL_DEDUP_EN
        expect_px(1923, 1'b1);
`else
        for (int i = 0; i < 5; i++) expect_px(1923, 1'b1);
`endif
        expect_px(1923, 1'b0);
        for (int i = 0; i < 5; i++) drive(3, 3, 1'b1);
        drive(3, 3, 1'b0);
        idle(1);
        drain("repeat_drained");

        // Backpressure: 20 pixels with mem_ready low. One pixel sits in the
        // output register and 16 fill the FIFO, so 3 are dropped.
        idle(2);
        mem_ready = 1'b0;
        for (int i = 0; i < 17; i++) expect_px(6400 + i, i[0]);
        for (int i = 0; i < 20; i++) drive(11'(i), 10, i[0]);
        idle(4);
        chk("bp_fifo_full", fifo_full, 1);
        chk("bp_drop_count", drop_count, 3);
        chk("bp_overflow", overflow, 1);
        chk("bp_wr_en_held", wr_en, 1);
        chk("bp_wr_addr_held", wr_addr, 6400);
        mem_ready = 1'b1;
        drain("bp_drained");
        idle(2);
        chk("bp_after_fifo_full", fifo_full, 0);

        // Reset with 8 pixels queued: everything is discarded.
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive(11'(i), 30, 1'b1);
        idle(3);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_fifo_full", fifo_full, 0);
        chk("mid_rst_drop_count", drop_count, 0);
        chk("mid_rst_overflow", overflow, 0);
        mem_ready = 1'b1;
        idle(10);
        chk("mid_rst_no_stale", wr_en, 0);

        // Full FIFO with a simultaneous push and pop: no drop.
        mem_ready = 1'b0;
        for (int i = 0; i < 17; i++) expect_px(25600 + i, 1'b1);
        for (int i = 0; i < 17; i++) drive(11'(i), 40, 1'b1);
        idle(3);
        chk("pp_pre_fifo_full", fifo_full, 1);
        chk("pp_pre_drop_count", drop_count, 0);
        chk("pp_pre_wr_addr", wr_addr, 25600);
        expect_px(25700, 1'b0);
        drive(100, 40, 1'b0);        // edge k
        pixel_valid = 1'b0;
        tick();                      // k+1
        mem_ready = 1'b1;
        tick();                      // k+2: pop and push together
        mem_ready = 1'b0;
        idle(2);
        chk("pp_fifo_full", fifo_full, 1);
        chk("pp_drop_count", drop_count, 0);
        chk("pp_overflow", overflow, 0);
        chk("pp_wr_addr", wr_addr, 25601);
        mem_ready = 1'b1;
        drain("pp_drained");
        idle(3);
        chk("final_wr_en", wr_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
